// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the buffer FSM state type and the default buffer sizing.
package uart_pkg;

  localparam int unsigned UART_DW = 8;

  localparam int unsigned TX_BUF_DEPTH_DEFAULT        = 16;
  localparam int unsigned TX_BUF_BUSY_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StStrobe   = 3'd2,
    StWaitBusy = 3'd3,
    StWaitDone = 3'd4
  } tx_buf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with same-cycle push/pop and a first-word-fall-through head.
// The caller qualifies push/pop; pointers carry one extra bit so level = wr - rd.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = TX_BUF_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [UART_DW-1:0] wdata,
  output logic [UART_DW-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level
);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [UART_DW-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer in front of the UART: FIFO plus a handshake FSM pacing bytes on send_over.
// Optional statistics counters are enabled with the UART_TX_BUFFER_STATS_EN macro.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = TX_BUF_DEPTH_DEFAULT,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned BUSY_TIMEOUT = TX_BUF_BUSY_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level,
  output logic               overflow,
  output logic               timeout,
  output logic [UART_DW-1:0] uart_din,
  output logic               uart_wrn,
  input  logic               uart_send_over
`ifdef UART_TX_BUFFER_STATS_EN
  ,
  output logic [15:0]        tx_count,
  output logic [7:0]         drop_count
`endif
);

  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  tx_buf_state_t      state_q, state_d;
  logic [CW-1:0]      busy_cnt_q, busy_cnt_d;
  logic [UART_DW-1:0] din_q, din_d;
  logic               wrn_q, wrn_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic [UART_DW-1:0] fifo_rdata;
  logic               busy_expired;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken then.
  assign fifo_pop     = (state_q == StLoad);
  assign fifo_push    = wr_en && (!full || fifo_pop);
  assign busy_expired = (busy_cnt_q == CW'(BUSY_TIMEOUT - 1));

  uart_sync_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(wr_data),
    .rdata(fifo_rdata),
    .full (full),
    .empty(empty),
    .level(level)
  );

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = '0;
    timeout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && uart_send_over) begin
          state_d = StLoad;
        end
      end
      StLoad:   state_d = StStrobe;
      StStrobe: state_d = StWaitBusy;
      StWaitBusy: begin
        if (!uart_send_over) begin
          state_d = StWaitDone;
        end else if (busy_expired) begin
          // Transmitter never acknowledged; treat the byte as sent and move on.
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (uart_send_over) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    din_d      = fifo_pop ? fifo_rdata : din_q;
    wrn_d      = (state_d != StStrobe);
    overflow_d = wr_en && !fifo_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_cnt_q <= '0;
      din_q      <= '0;
      wrn_q      <= 1'b1;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      din_q      <= din_d;
      wrn_q      <= wrn_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign uart_din = din_q;
  assign uart_wrn = wrn_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

`ifdef UART_TX_BUFFER_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    tx_count_d   = tx_count_q + {15'd0, (state_q == StStrobe)};
    drop_count_d = drop_count_q;
    if (overflow_d && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_count   = tx_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized scoreboard bench for uart_tx_buffer with a behavioural transmitter model.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned BUSY_TIMEOUT = 1024;
  localparam int TxNormal = 0;
  localparam int TxStuck  = 1;
  localparam int TxHold   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       timeout;
  logic [7:0] uart_din;
  logic       uart_wrn;
  logic       uart_send_over;
`ifdef UART_TX_BUFFER_STATS_EN
  logic [15:0] tx_count;
  logic [7:0]  drop_count;
`endif

  uart_tx_buffer #(
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .timeout       (timeout),
    .uart_din      (uart_din),
    .uart_wrn      (uart_wrn),
    .uart_send_over(uart_send_over)
`ifdef UART_TX_BUFFER_STATS_EN
    ,
    .tx_count      (tx_count),
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         strobe_cycs[$];
  int         tmo_cycs[$];
  int         strobe_count = 0;
  int         ovf_exp = 0, ovf_seen = 0;
  int         tmo_exp = 0, tmo_seen = 0;
  logic       wrn_prev = 1'b1;

  // Transmitter model: after a strobe, send_over falls tx_fall_dly cycles later
  // and stays low for tx_busy_len cycles.
  int   tx_mode     = TxNormal;
  int   tx_fall_dly = 2;
  int   tx_busy_len = 20;
  int   tx_phase    = 0;
  int   tx_timer    = 0;
  logic so          = 1'b1;
  assign uart_send_over = so;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_mode == TxHold) begin
        so       = 1'b0;
        tx_phase = 0;
      end else begin
        case (tx_phase)
          0: begin
            so = 1'b1;
            if (!uart_wrn && tx_mode == TxNormal) begin
              tx_phase = 1;
              tx_timer = tx_fall_dly;
            end
          end
          1: begin
            tx_timer--;
            if (tx_timer <= 0) begin
              so       = 1'b0;
              tx_phase = 2;
              tx_timer = tx_busy_len;
            end
          end
          default: begin
            tx_timer--;
            if (tx_timer <= 0) begin
              so       = 1'b1;
              tx_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: compares every strobe, overflow and timeout against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!uart_wrn) begin
        strobe_count++;
        strobe_cycs.push_back(cyc);
        check("wrn_single_cycle", wrn_prev, 1'b1);
        check("strobe_while_idle", uart_send_over, 1'b1);
        check("strobe_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("strobe_byte", uart_din, exp_q.pop_front());
      end
      if (overflow) begin
        check("overflow_expected", ovf_seen < ovf_exp, 1'b1);
        ovf_seen++;
      end
      if (timeout) begin
        check("timeout_expected", tmo_seen < tmo_exp, 1'b1);
        tmo_seen++;
        tmo_cycs.push_back(cyc);
      end
      wrn_prev = uart_wrn;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_mode(input int m);
    @(posedge clk);
    #1;
    tx_mode = m;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 6 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      if (exp_q.size() == 0 && tx_phase == 0 && uart_wrn && uart_send_over) quiet++;
      else quiet = 0;
    end
    check({name, "_done"}, k < budget, 1'b1);
    check({name, "_empty"}, empty, 1'b1);
    check({name, "_level"}, level, 0);
  endtask

  // Pushes while the transmitter is held busy, so nothing is popped.
  task automatic hold_fill(input int n);
    int occ = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      if (occ < int'(DEPTH)) begin
        exp_q.push_back(wr_data);
        occ++;
      end else begin
        ovf_exp++;
      end
      @(posedge clk);
      #1;
      check("fill_level", level, occ);
      check("fill_full", full, occ == int'(DEPTH));
      check("fill_empty", empty, occ == 0);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int push_cyc;
    int base;
    int k;
    int n;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_din", uart_din, 8'h00);
    check("rst_wrn", uart_wrn, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte: strobe two cycles after the push edge
    base = strobe_cycs.size();
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    push_cyc = cyc;
    check("push_empty", empty, 1'b0);
    check("push_level", level, 1);
    @(negedge clk);
    wr_en = 1'b0;
    k = 0;
    while (strobe_cycs.size() == base && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first_strobe_seen", strobe_cycs.size() > base, 1'b1);
    if (strobe_cycs.size() > base) check("first_strobe_latency", strobe_cycs[base] - push_cyc, 2);
    drain("single", 200);

    // Three bytes paced by the transmitter
    base = strobe_count;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    drain("three", 500);
    check("three_strobes", strobe_count - base, 3);

    // Randomized fill/overflow/drain rounds
    for (int r = 0; r < 3; r++) begin
      set_mode(TxHold);
      n = (r == 0) ? 17 : int'($urandom_range(10, 22));
      hold_fill(n);
      tx_fall_dly = int'($urandom_range(1, 3));
      tx_busy_len = int'($urandom_range(1, 10));
      set_mode(TxNormal);
      drain("round", 2000);
      check("round_overflows", ovf_seen, ovf_exp);
    end

    // Full FIFO with push and pop in the same cycle
    set_mode(TxHold);
    hold_fill(16);
    @(posedge clk);
    #1;
    tx_mode = TxNormal;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'($urandom);
    exp_q.push_back(wr_data);
    @(posedge clk);
    #1;
    check("pushpop_level", level, 16);
    check("pushpop_full", full, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("pushpop_no_overflow", overflow, 1'b0);
    drain("pushpop", 2000);

    // Stuck transmitter: both bytes time out
    set_mode(TxStuck);
    base = strobe_cycs.size();
    n    = tmo_cycs.size();
    tmo_exp += 2;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hB1;
    exp_q.push_back(8'hB1);
    @(negedge clk);
    wr_data = 8'hB2;
    exp_q.push_back(8'hB2);
    @(negedge clk);
    wr_en = 1'b0;
    k = 0;
    while ((tmo_cycs.size() < n + 2 || strobe_cycs.size() < base + 2) && k < 2300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("timeouts_seen", tmo_cycs.size() - n, 2);
    if (tmo_cycs.size() >= n + 2 && strobe_cycs.size() >= base + 2) begin
      check("timeout1_latency", tmo_cycs[n] - strobe_cycs[base], BUSY_TIMEOUT + 1);
      check("restrobe_after_timeout", strobe_cycs[base + 1] - tmo_cycs[n], 2);
      check("timeout2_latency", tmo_cycs[n + 1] - strobe_cycs[base + 1], BUSY_TIMEOUT + 1);
    end
    set_mode(TxNormal);
    drain("timeout", 50);

    // Reset while waiting for the transmitter with 5 bytes queued
    tx_fall_dly = 2;
    tx_busy_len = 40;
    base = strobe_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      exp_q.push_back(wr_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
    k = 0;
    while (strobe_count == base && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_mid_strobe_seen", strobe_count - base, 1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_queued", level, 5);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_full", full, 1'b0);
    check("rst_mid_level", level, 0);
    check("rst_mid_overflow", overflow, 1'b0);
    check("rst_mid_timeout", timeout, 1'b0);
    check("rst_mid_din", uart_din, 8'h00);
    check("rst_mid_wrn", uart_wrn, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    base = strobe_count;
    repeat (80) @(posedge clk);
    #1;
    check("rst_mid_no_strobe", strobe_count - base, 0);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    wr_en = 1'b0;
    drain("after_rst", 300);
    check("after_rst_strobe", strobe_count - base, 1);

    check("final_overflows", ovf_seen, ovf_exp);
    check("final_timeouts", tmo_seen, tmo_exp);
    check("final_scoreboard", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
